// File: rtl/MD_pkg.sv
// Shared definitions for the Lennard-Jones coefficient table.
//   ELEMENT_WIDTH   bits per element code (code 0 = no element)
//   FLOAT_WIDTH     width of one IEEE-754 single coefficient
//   lj_load_state_t loader FSM states
//   lj_coeff_t      one table entry {coeff_8, coeff_14}
package MD_pkg;

    localparam int ELEMENT_WIDTH = 2;
    localparam int FLOAT_WIDTH   = 32;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        ARMED   = 2'd2
    } lj_load_state_t;

    typedef struct packed {
        logic [FLOAT_WIDTH-1:0] coeff_8;
        logic [FLOAT_WIDTH-1:0] coeff_14;
    } lj_coeff_t;

endpackage

// File: rtl/lj_coeff_regfile.sv
// Coefficient storage for the LJ table.
// One write port (optionally also writing the mirrored index), one registered
// read port, per-entry valid bits with synchronous clear.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   we_i, mirror_i      write enable; also write {b,a} when mirror_i=1
//   waddr_i, wdata_i    write index {a,b} and packed {coeff_8, coeff_14}
//   clr_i               clear all valid bits (coefficients are kept)
//   re_i, raddr_i       read request and index
//   rd_armed_i          table is armed; otherwise every read misses
//   rvalid_o, rdata_o   registered read result
//   rmiss_o             registered miss flag
module lj_coeff_regfile
    import MD_pkg::*;
#(
    parameter int ADDR_W = 2 * ELEMENT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we_i,
    input  logic                          mirror_i,
    input  logic [ADDR_W-1:0]             waddr_i,
    input  logic [$bits(lj_coeff_t)-1:0]  wdata_i,
    input  logic                          clr_i,
    input  logic                          re_i,
    input  logic [ADDR_W-1:0]             raddr_i,
    input  logic                          rd_armed_i,
    output logic                          rvalid_o,
    output logic [$bits(lj_coeff_t)-1:0]  rdata_o,
    output logic                          rmiss_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int HALF  = ADDR_W / 2;

    lj_coeff_t               mem_q [DEPTH];
    logic [DEPTH-1:0]        valid_q;
    logic                    rvalid_q;
    lj_coeff_t               rdata_q;
    logic                    rmiss_q;
    logic [ADDR_W-1:0]       maddr;

    assign maddr = {waddr_i[HALF-1:0], waddr_i[ADDR_W-1:HALF]};

    // Coefficient storage is deliberately not reset or cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((ADDR_W'(i) == waddr_i) || (mirror_i && (ADDR_W'(i) == maddr))) begin
                    mem_q[i] <= lj_coeff_t'(wdata_i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clr_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((ADDR_W'(i) == waddr_i) || (mirror_i && (ADDR_W'(i) == maddr))) begin
                    valid_q[i] <= 1'b1;
                end
            end
        end
    end

    // Read samples storage before any same-cycle write lands, so a lookup
    // colliding with a write returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rmiss_q  <= 1'b0;
        end else begin
            rvalid_q <= re_i;
            if (re_i) begin
                if (rd_armed_i && valid_q[raddr_i]) begin
                    rdata_q <= mem_q[raddr_i];
                    rmiss_q <= 1'b0;
                end else begin
                    rdata_q <= '0;
                    rmiss_q <= 1'b1;
                end
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign rmiss_o  = rmiss_q;

endmodule

// File: rtl/lj_coeff_table_loader.sv
// Programmable Lennard-Jones coefficient table: loads (pair, coeff_8, coeff_14)
// records over a valid/ready stream, then serves pair lookups with one cycle
// of registered latency.
// Build option: LJ_COEFF_SYMMETRIC_EN -- each record also writes {elem_b, elem_a}.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   i_cfg_valid / o_cfg_ready           config handshake
//   i_cfg_elements, i_cfg_coeff_8/_14   record contents
//   i_cfg_last                          final record, arms the table
//   i_reload                            in ARMED: unlock and clear for new load
//   i_lookup_valid, i_lookup_elements   lookup request
//   o_lookup_valid, o_coeff_8/_14       lookup result (held while not valid)
//   o_lookup_miss                       unwritten entry or table not armed
//   o_table_armed, o_load_count         status
//   o_cfg_error                         sticky: record with element code 0 seen
//
// state   | meaning
// EMPTY   | no records accepted since reset/reload
// LOADING | records arriving, table not yet usable
// ARMED   | load complete, table locked, lookups can hit
module lj_coeff_table_loader
    import MD_pkg::*;
#(
    parameter int ELEMENT_WIDTH = MD_pkg::ELEMENT_WIDTH,
    parameter int FLOAT_WIDTH   = MD_pkg::FLOAT_WIDTH,
    parameter int DEPTH         = 2 ** (2 * ELEMENT_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_cfg_valid,
    output logic                       o_cfg_ready,
    input  logic [2*ELEMENT_WIDTH-1:0] i_cfg_elements,
    input  logic [FLOAT_WIDTH-1:0]     i_cfg_coeff_8,
    input  logic [FLOAT_WIDTH-1:0]     i_cfg_coeff_14,
    input  logic                       i_cfg_last,
    input  logic                       i_reload,
    input  logic                       i_lookup_valid,
    input  logic [2*ELEMENT_WIDTH-1:0] i_lookup_elements,
    output logic                       o_lookup_valid,
    output logic [FLOAT_WIDTH-1:0]     o_coeff_8,
    output logic [FLOAT_WIDTH-1:0]     o_coeff_14,
    output logic                       o_lookup_miss,
    output logic                       o_table_armed,
    output logic [2*ELEMENT_WIDTH:0]   o_load_count,
    output logic                       o_cfg_error
);

    localparam int                ADDR_W  = 2 * ELEMENT_WIDTH;
    localparam int                CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);

`ifdef LJ_COEFF_SYMMETRIC_EN
    localparam logic MIRROR = 1'b1;
`else
    localparam logic MIRROR = 1'b0;
`endif

    lj_load_state_t      state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;
    logic                cfg_ready;
    logic                accept;
    logic                reserved;
    logic                wr_en;
    logic                clr;
    logic [2*FLOAT_WIDTH-1:0] rdata;

    assign cfg_ready = (state_q != ARMED);
    assign accept    = i_cfg_valid && cfg_ready;
    assign reserved  = (i_cfg_elements[ADDR_W-1:ELEMENT_WIDTH] == '0) ||
                       (i_cfg_elements[ELEMENT_WIDTH-1:0] == '0);
    assign wr_en     = accept && !reserved;
    assign clr       = (state_q == ARMED) && i_reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) state_d = i_cfg_last ? ARMED : LOADING;
            end
            LOADING: begin
                if (accept && i_cfg_last) state_d = ARMED;
            end
            ARMED: begin
                if (i_reload) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        if (clr) begin
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (wr_en && (count_q != CNT_MAX)) count_d = count_q + 1'b1;
            // Dropped records still count as accepted for FSM purposes.
            if (accept && reserved) err_d = 1'b1;
        end
    end

    lj_coeff_regfile #(
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (wr_en),
        .mirror_i   (MIRROR),
        .waddr_i    (i_cfg_elements),
        .wdata_i    ({i_cfg_coeff_8, i_cfg_coeff_14}),
        .clr_i      (clr),
        .re_i       (i_lookup_valid),
        .raddr_i    (i_lookup_elements),
        .rd_armed_i (state_q == ARMED),
        .rvalid_o   (o_lookup_valid),
        .rdata_o    (rdata),
        .rmiss_o    (o_lookup_miss)
    );

    assign o_coeff_8     = rdata[2*FLOAT_WIDTH-1:FLOAT_WIDTH];
    assign o_coeff_14    = rdata[FLOAT_WIDTH-1:0];
    assign o_cfg_ready   = cfg_ready;
    assign o_table_armed = (state_q == ARMED);
    assign o_load_count  = count_q;
    assign o_cfg_error   = err_q;

endmodule

// File: tb/tb_lj_coeff_table_loader.sv
module tb_lj_coeff_table_loader;

    logic        clk;
    logic        rst_n;
    logic        i_cfg_valid;
    logic        o_cfg_ready;
    logic [3:0]  i_cfg_elements;
    logic [31:0] i_cfg_coeff_8;
    logic [31:0] i_cfg_coeff_14;
    logic        i_cfg_last;
    logic        i_reload;
    logic        i_lookup_valid;
    logic [3:0]  i_lookup_elements;
    logic        o_lookup_valid;
    logic [31:0] o_coeff_8;
    logic [31:0] o_coeff_14;
    logic        o_lookup_miss;
    logic        o_table_armed;
    logic [4:0]  o_load_count;
    logic        o_cfg_error;

    int n_checks = 0;
    int n_fail   = 0;

    lj_coeff_table_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_cfg_valid       (i_cfg_valid),
        .o_cfg_ready       (o_cfg_ready),
        .i_cfg_elements    (i_cfg_elements),
        .i_cfg_coeff_8     (i_cfg_coeff_8),
        .i_cfg_coeff_14    (i_cfg_coeff_14),
        .i_cfg_last        (i_cfg_last),
        .i_reload          (i_reload),
        .i_lookup_valid    (i_lookup_valid),
        .i_lookup_elements (i_lookup_elements),
        .o_lookup_valid    (o_lookup_valid),
        .o_coeff_8         (o_coeff_8),
        .o_coeff_14        (o_coeff_14),
        .o_lookup_miss     (o_lookup_miss),
        .o_table_armed     (o_table_armed),
        .o_load_count      (o_load_count),
        .o_cfg_error       (o_cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [3:0] el, input logic [31:0] c8, input logic [31:0] c14,
                       input logic last);
        i_cfg_valid    = 1'b1;
        i_cfg_elements = el;
        i_cfg_coeff_8  = c8;
        i_cfg_coeff_14 = c14;
        i_cfg_last     = last;
    endtask

    task automatic lookup(input logic [3:0] el);
        i_lookup_valid    = 1'b1;
        i_lookup_elements = el;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        i_cfg_valid    = 1'b0;
        i_cfg_last     = 1'b0;
        i_reload       = 1'b0;
        i_lookup_valid = 1'b0;
    endtask

    task automatic check_hit(input string tag, input logic [31:0] c8, input logic [31:0] c14);
        check({tag, "_valid"}, o_lookup_valid, 1'b1);
        check({tag, "_c8"},    o_coeff_8, c8);
        check({tag, "_c14"},   o_coeff_14, c14);
        check({tag, "_miss"},  o_lookup_miss, 1'b0);
    endtask

    task automatic check_miss(input string tag);
        check({tag, "_valid"}, o_lookup_valid, 1'b1);
        check({tag, "_c8"},    o_coeff_8, 32'h0);
        check({tag, "_c14"},   o_coeff_14, 32'h0);
        check({tag, "_miss"},  o_lookup_miss, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, o_cfg_ready, 1'b1);
        check({tag, "_lv"},    o_lookup_valid, 1'b0);
        check({tag, "_c8"},    o_coeff_8, 32'h0);
        check({tag, "_c14"},   o_coeff_14, 32'h0);
        check({tag, "_miss"},  o_lookup_miss, 1'b0);
        check({tag, "_armed"}, o_table_armed, 1'b0);
        check({tag, "_count"}, o_load_count, 5'd0);
        check({tag, "_err"},   o_cfg_error, 1'b0);
    endtask

    initial begin
        rst_n             = 1'b0;
        i_cfg_valid       = 1'b0;
        i_cfg_elements    = '0;
        i_cfg_coeff_8     = '0;
        i_cfg_coeff_14    = '0;
        i_cfg_last        = 1'b0;
        i_reload          = 1'b0;
        i_lookup_valid    = 1'b0;
        i_lookup_elements = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("rst");

        // First record plus a colliding lookup: table not armed -> miss.
        cfg(4'b0101, 32'h3F800000, 32'h40000000, 1'b0);
        lookup(4'b0101);
        step();
        check_miss("lk_first_wr");
        check("cnt1", o_load_count, 5'd1);
        check("armed_loading", o_table_armed, 1'b0);
        check("ready_loading", o_cfg_ready, 1'b1);

        // Last record; lookup in the acceptance cycle still misses.
        cfg(4'b1010, 32'h40400000, 32'h40800000, 1'b1);
        lookup(4'b0101);
        step();
        check_miss("lk_last_cycle");
        check("armed", o_table_armed, 1'b1);
        check("ready_armed", o_cfg_ready, 1'b0);
        check("cnt2", o_load_count, 5'd2);

        lookup(4'b0101);
        step();
        check_hit("lk_0101", 32'h3F800000, 32'h40000000);

        step();
        check("hold_lv", o_lookup_valid, 1'b0);
        check("hold_c8", o_coeff_8, 32'h3F800000);
        check("hold_c14", o_coeff_14, 32'h40000000);

        lookup(4'b1010);
        step();
        check_hit("lk_1010", 32'h40400000, 32'h40800000);

        // Config traffic while ARMED must be ignored.
        cfg(4'b0101, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
        step();
        check("armed_ready0", o_cfg_ready, 1'b0);
        check("armed_cnt", o_load_count, 5'd2);
        lookup(4'b0101);
        step();
        check_hit("lk_locked", 32'h3F800000, 32'h40000000);

        lookup(4'b0110);
        step();
        check_miss("lk_unwritten");

        // Reload: counters cleared, ready next cycle, valid bits cleared.
        i_reload = 1'b1;
        step();
        check("rl_ready", o_cfg_ready, 1'b1);
        check("rl_armed", o_table_armed, 1'b0);
        check("rl_cnt", o_load_count, 5'd0);
        lookup(4'b0101);
        step();
        check_miss("lk_after_reload");

        // Reserved element code: dropped, error set, count unchanged.
        cfg(4'b0001, 32'h11111111, 32'h22222222, 1'b0);
        step();
        check("err_set", o_cfg_error, 1'b1);
        check("err_cnt", o_load_count, 5'd0);
        check("err_loading", o_cfg_ready, 1'b1);

        cfg(4'b0110, 32'h3E800000, 32'h3F000000, 1'b1);
        step();
        check("sym_armed", o_table_armed, 1'b1);
        check("sym_cnt", o_load_count, 5'd1);
        check("err_sticky", o_cfg_error, 1'b1);

        lookup(4'b0110);
        step();
        check_hit("lk_0110", 32'h3E800000, 32'h3F000000);

        lookup(4'b1001);
        step();
`ifdef LJ_COEFF_SYMMETRIC_EN
        check_hit("lk_mirror", 32'h3E800000, 32'h3F000000);
`else
        check_miss("lk_mirror");
`endif

        lookup(4'b0001);
        step();
        check_miss("lk_reserved");

        i_reload = 1'b1;
        step();
        check("rl2_err", o_cfg_error, 1'b0);
        check("rl2_cnt", o_load_count, 5'd0);
        check("rl2_ready", o_cfg_ready, 1'b1);

        // Count saturates at DEPTH=16, overwrites still count.
        for (int i = 0; i < 17; i++) begin
            cfg(4'b0101, 32'h0000_1000 + 32'(i), 32'h0000_2000 + 32'(i), 1'b0);
            step();
        end
        check("cnt_sat", o_load_count, 5'd16);

        // Reset mid-load with a lookup in flight.
        cfg(4'b1010, 32'hAAAA5555, 32'h5555AAAA, 1'b0);
        lookup(4'b0101);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        i_cfg_valid    = 1'b0;
        i_lookup_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cfg(4'b0101, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        lookup(4'b1010);
        step();
        check_miss("lk_post_rst_empty");
        check("post_rst_cnt", o_load_count, 5'd1);
        lookup(4'b1010);
        step();
        check_miss("lk_post_rst_cleared");
        lookup(4'b0101);
        step();
        check_hit("lk_post_rst_hit", 32'h12345678, 32'h9ABCDEF0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
